uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter (`UART_SEND_TOP`) among `N_REQ` byte-stream requesters. It accepts bytes through per-requester valid/ready handshakes and issues one-cycle `send_en` pulses with `data_byte`/`baud_set`. It waits for the transmitter's `tx_done` before starting the next byte. Optional packet lock keeps the grant on one requester until its `last` byte, so multi-byte messages are never interleaved.

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT,
      HOLD
   } arb_state_t;

   localparam logic [2:0] BAUD_115200 = 3'd4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bundle: one valid/ready/last lane and one byte per requester.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);

   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;

   modport master (
      output req_valid,
      output req_data,
      output req_last,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  req_last,
      output req_ready
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant_oh,
   output logic [W-1:0] grant_idx,
   output logic         found
);

   localparam int W1 = W + 1;

   logic [W:0]   sum;
   logic [W-1:0] idx;

   // One extra bit keeps ptr+i from overflowing before the modulo fold.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + W1'(i);
         if (sum >= W1'(N)) begin
            sum = sum - W1'(N);
         end
         idx = sum[W-1:0];
         if (!found && req[idx]) begin
            found         = 1'b1;
            grant_oh[idx] = 1'b1;
            grant_idx     = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters, round robin,
// optionally keeping the grant on one requester until the end of its packet.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int         N_REQ        = 4,
   parameter bit         LOCK_EN      = 1'b1,
   parameter int         HOLD_TIMEOUT = 1024,
   parameter logic [2:0] BAUD_DEFAULT = BAUD_115200,
   localparam int        GW           = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 nrst,
   uart_tx_arbiter_if.slave     req,
   input  logic [2:0]           cfg_baud_set,
   input  logic                 tx_done,
   input  logic                 uart_state,
   output logic [7:0]           data_byte,
   output logic [2:0]           baud_set,
   output logic                 send_en,
   output logic [GW-1:0]        grant_id,
   output logic                 busy
);

   localparam int CW = $clog2(HOLD_TIMEOUT + 1);

   arb_state_t       state;
   logic [GW-1:0]    ptr;
   logic [GW-1:0]    next_ptr;
   logic             last_flag;
   logic             tx_done_q;
   logic             tx_done_rise;
   logic [CW-1:0]    hold_cnt;
   logic [N_REQ-1:0] req_ready_q;
   logic [N_REQ-1:0] grant_oh_cur;
   logic [N_REQ-1:0] pick_oh;
   logic [GW-1:0]    pick_idx;
   logic             pick_found;
   logic [7:0]       sel_data;
   logic             sel_last;

   rr_pick #(
      .N (N_REQ),
      .W (GW)
   ) u_pick (
      .req       (req.req_valid),
      .ptr       (ptr),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .found     (pick_found)
   );

   assign req.req_ready = req_ready_q;
   assign busy          = (state != IDLE);
   assign tx_done_rise  = tx_done & ~tx_done_q;
   assign grant_oh_cur  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
   assign next_ptr      = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == GW'(i)) begin
            sel_data = req.req_data[8*i +: 8];
            sel_last = req.req_last[i];
         end
      end
   end

   // send_en is raised on the LOAD->SEND edge when the transmitter is idle so
   // the start pulse lands one cycle after the byte is taken; SEND retries
   // until uart_state drops and then leaves after the pulse cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         send_en     <= 1'b0;
         req_ready_q <= '0;
         data_byte   <= '0;
         baud_set    <= BAUD_DEFAULT;
         grant_id    <= '0;
         ptr         <= '0;
         hold_cnt    <= '0;
         last_flag   <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         tx_done_q <= tx_done;
         send_en   <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id    <= pick_idx;
                  baud_set    <= cfg_baud_set;
                  req_ready_q <= pick_oh;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               req_ready_q <= '0;
               data_byte   <= sel_data;
               last_flag   <= sel_last;
               send_en     <= ~uart_state;
               state       <= SEND;
            end
            SEND: begin
               if (send_en) begin
                  state <= WAIT;
               end else if (!uart_state) begin
                  send_en <= 1'b1;
               end
            end
            WAIT: begin
               if (tx_done_rise) begin
                  if (!LOCK_EN || last_flag) begin
                     state <= IDLE;
                     ptr   <= next_ptr;
                  end else begin
                     state    <= HOLD;
                     hold_cnt <= '0;
                  end
               end
            end
            HOLD: begin
               if (req.req_valid[grant_id]) begin
                  req_ready_q <= grant_oh_cur;
                  state       <= LOAD;
               end else if (hold_cnt == CW'(HOLD_TIMEOUT - 1)) begin
                  state <= IDLE;
                  ptr   <= next_ptr;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with requester and transmitter models.
module tb_uart_tx_arbiter;

   localparam int N      = 4;
   localparam int TOUT   = 16;
   localparam int TX_LEN = 6;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic [2:0] baud;
   } exp_t;

   logic       clk = 1'b0;
   logic       nrst;
   logic [2:0] cfg_baud_set;
   logic       tx_done;
   logic       uart_state;
   logic [7:0] data_byte;
   logic [2:0] baud_set;
   logic       send_en;
   logic [1:0] grant_id;
   logic       busy;
   logic       uart_busy_m;
   logic       force_busy;
   logic       tx_active;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int send_count = 0;
   int last_send_cyc = 0;
   int done_count = 0;
   int last_done_cyc = 0;

   exp_t       sb_q[$];
   logic [8:0] src_q[N][$];

   uart_tx_arbiter_if #(.N_REQ(N)) bus();

   uart_tx_arbiter #(
      .N_REQ        (N),
      .LOCK_EN      (1'b1),
      .HOLD_TIMEOUT (TOUT),
      .BAUD_DEFAULT (3'd4)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .req          (bus.slave),
      .cfg_baud_set (cfg_baud_set),
      .tx_done      (tx_done),
      .uart_state   (uart_state),
      .data_byte    (data_byte),
      .baud_set     (baud_set),
      .send_en      (send_en),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   assign uart_state = uart_busy_m | force_busy;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Requester model: present the head of each queue, retire it after a ready edge.
   initial begin : req_driver
      logic [N-1:0] rdy;
      logic [8:0]   head;
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      forever begin
         @(negedge clk);
         rdy = bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && rdy[i]) begin
               void'(src_q[i].pop_front());
               bus.req_valid[i] = 1'b0;
            end
            if (!bus.req_valid[i] && src_q[i].size() > 0) begin
               head = src_q[i][0];
               bus.req_valid[i]       = 1'b1;
               bus.req_data[8*i +: 8] = head[7:0];
               bus.req_last[i]        = head[8];
            end
         end
      end
   end

   // Transmitter model: busy for TX_LEN cycles after each start pulse, then one tx_done cycle.
   initial begin : tx_model
      uart_busy_m = 1'b0;
      tx_done     = 1'b0;
      tx_active   = 1'b0;
      forever begin
         @(negedge clk);
         if (nrst && send_en === 1'b1) begin
            tx_active = 1'b1;
            @(posedge clk);
            #1 uart_busy_m = 1'b1;
            repeat (TX_LEN) @(posedge clk);
            #1;
            uart_busy_m   = 1'b0;
            tx_done       = 1'b1;
            last_done_cyc = cyc;
            done_count    = done_count + 1;
            @(posedge clk);
            #1;
            tx_done   = 1'b0;
            tx_active = 1'b0;
         end
      end
   end

   initial begin : sb_monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (nrst && send_en === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_send: got unexpected send id=%0d data=%h, required no send", grant_id, data_byte);
            end else begin
               e = sb_q.pop_front();
               if (grant_id !== e.id || data_byte !== e.data || baud_set !== e.baud) begin
                  errors++;
                  $display("[TB] FAIL sb_send: got id=%0d data=%h baud=%0d, required id=%0d data=%h baud=%0d",
                           grant_id, data_byte, baud_set, e.id, e.data, e.baud);
               end
            end
            send_count    = send_count + 1;
            last_send_cyc = cyc;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_sends(input int target, input int budget);
      int n = 0;
      while (send_count < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (send_count < target) begin
         errors++;
         $display("[TB] FAIL wait_sends: got %0d sends, required %0d", send_count, target);
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_count < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (done_count < target) begin
         errors++;
         $display("[TB] FAIL wait_done: got %0d frames, required %0d", done_count, target);
      end
   endtask

   task automatic wait_quiet(input int budget);
      int n = 0;
      bit quiet = 1'b0;
      while (!quiet && n < budget) begin
         @(negedge clk);
         #1;
         n++;
         quiet = (busy === 1'b0) && (sb_q.size() == 0) && !tx_active && (bus.req_valid === '0);
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) quiet = 1'b0;
         end
      end
      checks++;
      if (!quiet) begin
         errors++;
         $display("[TB] FAIL quiet: got busy=%b pending=%0d, required idle and drained", busy, sb_q.size());
      end
   endtask

   task automatic test_reset();
      nrst         = 1'b0;
      cfg_baud_set = 3'd4;
      force_busy   = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks += 6;
      if (send_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_send_en: got %b, required 0", send_en); end
      if (bus.req_ready !== 4'b0) begin errors++; $display("[TB] FAIL rst_req_ready: got %b, required 0000", bus.req_ready); end
      if (data_byte !== 8'h00) begin errors++; $display("[TB] FAIL rst_data_byte: got %h, required 00", data_byte); end
      if (baud_set !== 3'd4) begin errors++; $display("[TB] FAIL rst_baud_set: got %0d, required 4", baud_set); end
      if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL rst_grant_id: got %0d, required 0", grant_id); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
      @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_contention();
      int base = send_count;
      logic [7:0] b;
      for (int i = 0; i < N; i++) begin
         b = 8'h10 + 8'(i);
         sb_q.push_back('{id: 2'(i), data: b, baud: 3'd4});
         src_q[i].push_back({1'b1, b});
      end
      wait_sends(base + 4, 400);
      wait_quiet(200);
      checks++;
      if (grant_id !== 2'd3) begin
         errors++;
         $display("[TB] FAIL contention_last_grant: got %0d, required 3", grant_id);
      end
   endtask

   task automatic test_single();
      int base = send_count;
      int vcyc = 0;
      int rcyc = 0;
      int n = 0;
      sb_q.push_back('{id: 2'd1, data: 8'hAA, baud: 3'd4});
      src_q[1].push_back({1'b1, 8'hAA});
      while (!bus.req_valid[1] && n < 20) begin @(negedge clk); #1; n++; end
      vcyc = cyc;
      n = 0;
      while (bus.req_ready === 4'b0 && n < 20) begin @(negedge clk); #1; n++; end
      rcyc = cyc;
      checks++;
      if (bus.req_ready !== 4'b0010 || rcyc != vcyc + 1) begin
         errors++;
         $display("[TB] FAIL single_ready: got %b at +%0d, required 0010 at +1", bus.req_ready, rcyc - vcyc);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0) begin
         errors++;
         $display("[TB] FAIL single_ready_width: got %b, required 0000", bus.req_ready);
      end
      wait_sends(base + 1, 50);
      checks++;
      if (last_send_cyc != vcyc + 2) begin
         errors++;
         $display("[TB] FAIL single_send_latency: got +%0d, required +2", last_send_cyc - vcyc);
      end
      n = 0;
      while (busy === 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      checks++;
      if (busy !== 1'b0 || cyc != last_done_cyc + 1) begin
         errors++;
         $display("[TB] FAIL single_busy_drop: got busy=%b at done+%0d, required 0 at done+1", busy, cyc - last_done_cyc);
      end
      checks++;
      if (grant_id !== 2'd1) begin
         errors++;
         $display("[TB] FAIL single_grant: got %0d, required 1", grant_id);
      end
      wait_quiet(50);
   endtask

   task automatic test_lock();
      int base = send_count;
      cfg_baud_set = 3'd4;
      sb_q.push_back('{id: 2'd2, data: 8'h55, baud: 3'd4});
      sb_q.push_back('{id: 2'd2, data: 8'h56, baud: 3'd4});
      sb_q.push_back('{id: 2'd0, data: 8'h77, baud: 3'd6});
      src_q[2].push_back({1'b0, 8'h55});
      src_q[2].push_back({1'b1, 8'h56});
      src_q[0].push_back({1'b1, 8'h77});
      wait_sends(base + 1, 50);
      cfg_baud_set = 3'd6;
      wait_sends(base + 2, 50);
      checks++;
      if (last_send_cyc != last_done_cyc + 3) begin
         errors++;
         $display("[TB] FAIL lock_same_packet_latency: got done+%0d, required done+3", last_send_cyc - last_done_cyc);
      end
      checks++;
      if (bus.req_valid[0] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lock_req0_pending: got valid=%b, required 1", bus.req_valid[0]);
      end
      wait_sends(base + 3, 60);
      wait_quiet(60);
   endtask

   task automatic test_timeout();
      int base = send_count;
      int d;
      cfg_baud_set = 3'd4;
      sb_q.push_back('{id: 2'd3, data: 8'h01, baud: 3'd4});
      src_q[3].push_back({1'b0, 8'h01});
      wait_sends(base + 1, 50);
      wait_done(done_count + 1, 50);
      d = last_done_cyc;
      while (cyc < d + 16) begin @(negedge clk); #1; end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_hold_early: got busy=%b, required 1", busy); end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_exit: got busy=%b, required 0", busy); end
      sb_q.push_back('{id: 2'd0, data: 8'h21, baud: 3'd4});
      sb_q.push_back('{id: 2'd1, data: 8'h22, baud: 3'd4});
      src_q[0].push_back({1'b1, 8'h21});
      src_q[1].push_back({1'b1, 8'h22});
      wait_sends(base + 3, 100);
      wait_quiet(60);

      // A valid arriving in the very cycle the count expires must still win.
      base = send_count;
      sb_q.push_back('{id: 2'd3, data: 8'h31, baud: 3'd4});
      sb_q.push_back('{id: 2'd3, data: 8'h32, baud: 3'd4});
      src_q[3].push_back({1'b0, 8'h31});
      wait_sends(base + 1, 50);
      wait_done(done_count + 1, 50);
      d = last_done_cyc;
      while (cyc < d + 15) begin @(negedge clk); #1; end
      src_q[3].push_back({1'b1, 8'h32});
      while (cyc < d + 17) begin @(negedge clk); #1; end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_edge_busy: got busy=%b, required 1", busy); end
      wait_sends(base + 2, 20);
      checks++;
      if (last_send_cyc != d + 18) begin
         errors++;
         $display("[TB] FAIL timeout_edge_send: got done+%0d, required done+18", last_send_cyc - d);
      end
      wait_quiet(60);
   endtask

   task automatic test_busy_tx();
      int base = send_count;
      int n = 0;
      int bad = 0;
      int e;
      force_busy = 1'b1;
      sb_q.push_back('{id: 2'd1, data: 8'h44, baud: 3'd4});
      src_q[1].push_back({1'b1, 8'h44});
      while (bus.req_ready[1] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      repeat (100) begin
         @(negedge clk);
         #1;
         if (send_en !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL busy_hold: got %0d send cycles, required 0", bad); end
      force_busy = 1'b0;
      e = cyc;
      wait_sends(base + 1, 20);
      checks++;
      if (last_send_cyc != e + 1) begin
         errors++;
         $display("[TB] FAIL busy_release_send: got release+%0d, required release+1", last_send_cyc - e);
      end
      @(negedge clk);
      #1;
      checks++;
      if (send_en !== 1'b0) begin errors++; $display("[TB] FAIL busy_pulse_width: got %b, required 0", send_en); end
      wait_quiet(60);
   endtask

   task automatic test_reset_wait();
      int base = send_count;
      int n = 0;
      cfg_baud_set = 3'd5;
      sb_q.push_back('{id: 2'd3, data: 8'h99, baud: 3'd5});
      src_q[3].push_back({1'b1, 8'h99});
      wait_sends(base + 1, 50);
      @(negedge clk);
      nrst = 1'b0;
      #1;
      checks += 6;
      if (send_en !== 1'b0) begin errors++; $display("[TB] FAIL rstw_send_en: got %b, required 0", send_en); end
      if (bus.req_ready !== 4'b0) begin errors++; $display("[TB] FAIL rstw_req_ready: got %b, required 0000", bus.req_ready); end
      if (data_byte !== 8'h00) begin errors++; $display("[TB] FAIL rstw_data_byte: got %h, required 00", data_byte); end
      if (baud_set !== 3'd4) begin errors++; $display("[TB] FAIL rstw_baud_set: got %0d, required 4", baud_set); end
      if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL rstw_grant_id: got %0d, required 0", grant_id); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstw_busy: got %b, required 0", busy); end
      @(negedge clk);
      nrst = 1'b1;
      while (tx_active && n < 50) begin @(negedge clk); #1; n++; end
      base = send_count;
      sb_q.push_back('{id: 2'd2, data: 8'hA2, baud: 3'd5});
      sb_q.push_back('{id: 2'd3, data: 8'hA3, baud: 3'd5});
      src_q[2].push_back({1'b1, 8'hA2});
      src_q[3].push_back({1'b1, 8'hA3});
      wait_sends(base + 2, 100);
      wait_quiet(60);
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single();
      test_lock();
      test_timeout();
      test_busy_tx();
      test_reset_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
